sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in, parallel-out word receiver that sits at the far end of the 4-bit PISO serial link. It takes an MSB-first bit stream qualified by a per-bit valid and a start-of-word marker, and reassembles WIDTH-bit words. Each completed word goes into an output holding register with a valid/ready handshake. Framing errors and overruns are flagged so the consuming logic can detect lost or corrupted words.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- si  in  1  serial data bit, MSB of the word first.
- si_vld  in  1  qualifies si; exactly one bit is accepted per cycle with si_vld=1.
- si_start  in  1  marks the bit on si as the first (MSB) bit of a word; only meaningful when si_vld=1.
- dout  out  WIDTH  last completed word; bit WIDTH-1 = first received bit.
- dout_vld  out  1  dout holds an unconsumed word.
- dout_rdy  in  1  consumer accepts dout when dout_vld & dout_rdy.
- frame_err  out  1  single-cycle pulse: start marker inside a word, or data outside a word.
- overrun  out  1  single-cycle pulse: a completed word was dropped because dout was still occupied.

## Operation
- **Reset values:** FSM=IDLE, shift register=0, bit counter=0, dout=0, dout_vld=0, frame_err=0, overrun=0. A reset mid-word discards the partial word.
- **IDLE state**
  - si_vld & si_start: shift register <= {0..., si}, bit counter <= 1, go to SHIFT.
  - si_vld & !si_start: bit discarded, frame_err pulses, stay in IDLE.
- **SHIFT state**
  - si_vld & !si_start: shift register <= {sr[WIDTH-2:0], si}, counter increments.
  - si_vld & si_start: partial word discarded, frame_err pulses, a new word restarts with this bit as MSB, counter <= 1.
  - si_vld=0: hold; there is no timeout and gaps of any length are allowed between bits.
- **Word completion:** the accepted bit that brings the counter to WIDTH completes the word. The word is {sr[WIDTH-2:0], si}. The FSM returns to IDLE and the counter clears.
- **Output register**
  - Word completes while dout_vld=0: dout <= word, dout_vld <= 1.
  - Word completes while dout_vld=1 and dout_rdy=1 (same cycle): dout <= new word, dout_vld stays 1, no overrun.
  - Word completes while dout_vld=1 and dout_rdy=0: the new word is dropped, dout is unchanged, overrun pulses.
  - dout_vld & dout_rdy with no completion: dout_vld <= 0. dout keeps its last value.
- **Back-to-back words:** a start bit may be accepted in the cycle immediately after the completing bit.
- **Other rules:** the counter is ceil(log2(WIDTH+1)) bits wide and never exceeds WIDTH. Words are unsigned bit vectors with no arithmetic on them.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Latency: dout/dout_vld update on the same rising edge that samples the last bit with si_vld=1, so they are visible in the following cycle.
- Minimum word time is WIDTH cycles. Sustained throughput is one word per WIDTH cycles when dout_rdy is held at 1.
- frame_err and overrun are high for exactly one cycle, starting the cycle after the offending edge.
- dout_rdy is sampled only when dout_vld=1.
- rst is asynchronous assert; its deassertion is synchronous to clk by the system.

## Test plan
- **Single word:** WIDTH=4, dout_rdy=0, send 1,0,1,1 with si_start on the first bit and si_vld=1 for 4 cycles -> dout=4'b1011, dout_vld=1 one cycle after the 4th bit. Then dout_rdy=1 -> dout_vld=0 next cycle and dout stays 4'b1011.
- **Back-to-back with gaps:** dout_rdy=1; send 4'hA, then 4'h5 immediately, with a 3-cycle si_vld=0 gap inside the second word -> dout=4'hA then 4'h5, no frame_err and no overrun.
- **Overrun:** dout_rdy=0; send 4'h3 then 4'hC -> dout stays 4'h3, overrun pulses once on the 4'hC completion, dout_vld=1.
- **Handoff edge case:** send 4'hC, then complete 4'h9 with dout_rdy=1 exactly in its completion cycle -> dout=4'h9, dout_vld stays 1, overrun=0.
- **Framing errors**
  - After 2 bits of a word, assert si_start with the bits 0,1,1,0 -> frame_err pulses once, dout=4'h6.
  - si_vld=1 with si_start=0 while in IDLE -> frame_err pulses and dout is unchanged.
- **Reset mid-word:** after 3 bits of 4'hF, pulse rst asynchronously between clock edges -> all outputs 0 immediately. The next full word 4'h2 is received correctly with no frame_err.

Source files
------------

// File: rtl/sipo_rx.sv
// sipo_rx -- serial-in, parallel-out word receiver.
//
// Reassembles WIDTH-bit words from an MSB-first bit stream. Each accepted
// bit (si_vld=1) is shifted in; si_start marks the first bit of a word.
// Completed words land in a holding register with a valid/ready handshake.
// Framing errors (start inside a word, data outside a word) and overruns
// (word completed while the holding register is still full) are reported
// as single-cycle pulses.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   si        in   serial data bit, MSB first
//   si_vld    in   qualifies si, one bit accepted per valid cycle
//   si_start  in   si carries the first (MSB) bit of a word
//   dout      out  last completed word, bit WIDTH-1 = first received bit
//   dout_vld  out  dout holds an unconsumed word
//   dout_rdy  in   consumer takes dout when dout_vld & dout_rdy
//   frame_err out  one-cycle pulse on a framing violation
//   overrun   out  one-cycle pulse when a completed word is dropped
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_vld,
    input  logic             si_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    // Counter value before the bit that completes a word.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sr, sr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   word;
    logic               word_done;
    logic               ferr_set;

    // Next-state logic for the framing FSM and shift path.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        word      = {sr[WIDTH-2:0], si};
        word_done = 1'b0;
        ferr_set  = 1'b0;

        if (si_vld) begin
            if (si_start) begin
                // A start inside a word abandons the partial word and
                // restarts with this bit as the new MSB.
                ferr_set  = (state == SHIFT);
                sr_nxt    = {{(WIDTH-1){1'b0}}, si};
                cnt_nxt   = CNT_W'(1);
                state_nxt = SHIFT;
            end else if (state == IDLE) begin
                ferr_set = 1'b1;
            end else begin
                sr_nxt = word;
                if (cnt == LAST) begin
                    word_done = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output holding register. A completing word may replace dout only if
    // the slot is empty or is being consumed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= 1'b0;
            if (word_done) begin
                if (!dout_vld || dout_rdy) begin
                    dout     <= word;
                    dout_vld <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx (WIDTH=4): directed scenarios followed by random
// traffic, all checked every cycle against a word-level reference model.
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         si = 1'b0;
    logic         si_vld = 1'b0;
    logic         si_start = 1'b0;
    logic         dout_rdy = 1'b0;
    logic [W-1:0] dout;
    logic         dout_vld;
    logic         frame_err;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state: word in progress as an integer plus bit count.
    bit           m_inword = 1'b0;
    int           m_val = 0;
    int           m_n = 0;
    logic [W-1:0] exp_dout = '0;
    logic         exp_vld = 1'b0;
    logic         exp_ferr = 1'b0;
    logic         exp_ovr = 1'b0;

    sipo_rx #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .si       (si),
        .si_vld   (si_vld),
        .si_start (si_start),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},      32'(dout),      32'(exp_dout));
        check({tag, ".dout_vld"},  32'(dout_vld),  32'(exp_vld));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
        check({tag, ".overrun"},   32'(overrun),   32'(exp_ovr));
    endtask

    task automatic model_reset();
        m_inword = 1'b0;
        m_val    = 0;
        m_n      = 0;
        exp_dout = '0;
        exp_vld  = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // One clock edge of the specified behaviour, at word level.
    task automatic model_edge(input logic b, input logic v, input logic s, input logic r);
        bit done;
        done     = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (v) begin
            if (s) begin
                if (m_inword) exp_ferr = 1'b1;
                m_inword = 1'b1;
                m_val    = int'(b);
                m_n      = 1;
            end else if (!m_inword) begin
                exp_ferr = 1'b1;
            end else begin
                m_val = m_val * 2 + int'(b);
                m_n   = m_n + 1;
                if (m_n == W) begin
                    done     = 1'b1;
                    m_inword = 1'b0;
                    m_n      = 0;
                end
            end
        end
        if (done) begin
            if (!exp_vld || r) begin
                exp_dout = W'(m_val);
                exp_vld  = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (exp_vld && r) begin
            exp_vld = 1'b0;
        end
    endtask

    task automatic step(input logic b, input logic v, input logic s, input logic r, input string tag);
        si       = b;
        si_vld   = v;
        si_start = s;
        dout_rdy = r;
        @(posedge clk);
        model_edge(b, v, s, r);
        #1;
        check_all(tag);
    endtask

    // Send one word MSB first; optional idle gap after bit index gap_after
    // (0 = after MSB); r_last is dout_rdy during the completing bit.
    task automatic send_word(input logic [W-1:0] val, input int gap_after, input int gap_len,
                             input logic r, input logic r_last, input string tag);
        for (int i = W - 1; i >= 0; i--) begin
            step(val[i], 1'b1, i == W - 1, (i == 0) ? r_last : r, tag);
            if ((W - 1 - i) == gap_after)
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'b0, r, tag);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single word, held until consumed
        send_word(4'b1011, -1, 0, 1'b0, 1'b0, "single");
        check("single.dout_const", 32'(dout), 32'hB);
        check("single.vld_const", 32'(dout_vld), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "single_drain");
        check("single.vld_cleared", 32'(dout_vld), 32'h0);
        check("single.dout_kept", 32'(dout), 32'hB);

        // Back-to-back with an internal gap
        send_word(4'hA, -1, 0, 1'b1, 1'b1, "b2b_a");
        check("b2b.first", 32'(dout), 32'hA);
        send_word(4'h5, 1, 3, 1'b1, 1'b1, "b2b_5");
        check("b2b.second", 32'(dout), 32'h5);
        step(1'b0, 1'b0, 1'b0, 1'b1, "b2b_drain");

        // Overrun
        send_word(4'h3, -1, 0, 1'b0, 1'b0, "ovr_3");
        send_word(4'hC, -1, 0, 1'b0, 1'b0, "ovr_c");
        check("ovr.pulse", 32'(overrun), 32'h1);
        check("ovr.dout_kept", 32'(dout), 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b0, "ovr_after");
        check("ovr.single_cycle", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "ovr_drain");

        // Handoff: consume and refill in the same cycle
        send_word(4'hC, -1, 0, 1'b0, 1'b0, "hand_c");
        send_word(4'h9, -1, 0, 1'b0, 1'b1, "hand_9");
        check("hand.dout", 32'(dout), 32'h9);
        check("hand.vld", 32'(dout_vld), 32'h1);
        check("hand.no_ovr", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "hand_drain");

        // Framing: start inside a word, then data while idle
        step(1'b1, 1'b1, 1'b1, 1'b0, "ferr_partial");
        step(1'b1, 1'b1, 1'b0, 1'b0, "ferr_partial");
        step(1'b0, 1'b1, 1'b1, 1'b0, "ferr_restart");
        check("ferr.pulse", 32'(frame_err), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "ferr_word");
        check("ferr.single_cycle", 32'(frame_err), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "ferr_word");
        step(1'b0, 1'b1, 1'b0, 1'b0, "ferr_word");
        check("ferr.dout", 32'(dout), 32'h6);
        step(1'b1, 1'b1, 1'b0, 1'b0, "ferr_idle");
        check("ferr.idle_pulse", 32'(frame_err), 32'h1);
        check("ferr.idle_dout", 32'(dout), 32'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1, "ferr_drain");

        // Asynchronous reset mid-word
        step(1'b1, 1'b1, 1'b1, 1'b0, "rst_mid");
        step(1'b1, 1'b1, 1'b0, 1'b0, "rst_mid");
        step(1'b1, 1'b1, 1'b0, 1'b0, "rst_mid");
        si_vld = 1'b0;
        rst    = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst = 1'b0;
        send_word(4'h2, -1, 0, 1'b0, 1'b0, "rst_after");
        check("rst.after_word", 32'(dout), 32'h2);
        step(1'b0, 1'b0, 1'b0, 1'b1, "rst_drain");

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 2) != 0,
                 "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
